// File: rtl/csa_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module   : csa_accum_pipe
// Purpose  : Streaming three-operand carry-save accumulator. Each accepted
//            beat (a, b, c) is folded into redundant S/C registers through a
//            3:2 compressor followed by a 4:2 compressor. The terminal beat
//            of a frame starts a chunked ripple-carry resolve of S+C, CHUNK
//            bits per cycle, and the result is held until consumed.
// Ports    : clk, rst_n (async active-low)
//            in_valid/in_ready, in_a/in_b/in_c [WIDTH], in_last  - beat input
//            out_valid/out_ready, out_sum [OW], out_ovf          - result
// Options  : CSA_SIGNED_EN - operands are two's complement and sign-extended
//            (default: unsigned, zero-extended).
// Revision : 1.0 - initial release
// ============================================================================
module csa_accum_pipe #(
  parameter int WIDTH = 16,
  parameter int GUARD = 4,
  parameter int CHUNK = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [WIDTH-1:0]           in_c,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH+2+GUARD-1:0]   out_sum,
  output logic                       out_ovf
);

  localparam int OW = WIDTH + 2 + GUARD;
  localparam int NR = (OW + CHUNK - 1) / CHUNK;
  localparam int PW = NR * CHUNK;
  localparam int IW = (NR > 1) ? $clog2(NR) : 1;
  localparam int CW = GUARD + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]     state;
  logic           alive;       // low during reset so in_ready stays low
  logic [OW-1:0]  s_q, c_q;
  logic [CW-1:0]  count;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [OW-1:0]  res;
  logic           ovf;

  // Operand extension to the accumulator width
  logic [OW-1:0] ea, eb, ec;
`ifdef CSA_SIGNED_EN
  assign ea = {{(OW-WIDTH){in_a[WIDTH-1]}}, in_a};
  assign eb = {{(OW-WIDTH){in_b[WIDTH-1]}}, in_b};
  assign ec = {{(OW-WIDTH){in_c[WIDTH-1]}}, in_c};
`else
  assign ea = {{(OW-WIDTH){1'b0}}, in_a};
  assign eb = {{(OW-WIDTH){1'b0}}, in_b};
  assign ec = {{(OW-WIDTH){1'b0}}, in_c};
`endif

  // 3:2 on the operands, then a 4:2 (two chained 3:2 stages) merging the
  // operand pair with the running S/C. Everything wraps modulo 2^OW, which is
  // exact because the frame total fits in OW bits.
  logic [OW-1:0] s1, c1s, x1, y1s, s_nxt, c_nxt;
  always_comb begin
    s1    = ea ^ eb ^ ec;
    c1s   = ((ea & eb) | (ea & ec) | (eb & ec)) << 1;
    x1    = s1 ^ c1s ^ s_q;
    y1s   = ((s1 & c1s) | (s1 & s_q) | (c1s & s_q)) << 1;
    s_nxt = x1 ^ y1s ^ c_q;
    c_nxt = ((x1 & y1s) | (x1 & c_q) | (y1s & c_q)) << 1;
  end

  // One CHUNK-wide ripple slice of S+C selected by the resolve index.
  // S/C are padded to a whole number of chunks so the top slice is in range.
  logic [PW-1:0]  s_pad, c_pad;
  logic [CHUNK:0] slice;
  always_comb begin
    s_pad = '0;
    c_pad = '0;
    s_pad[OW-1:0] = s_q;
    c_pad[OW-1:0] = c_q;
    slice = {1'b0, s_pad[int'(idx)*CHUNK +: CHUNK]}
          + {1'b0, c_pad[int'(idx)*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, carry};
  end

  logic accept, at_limit, terminal;
  assign in_ready  = alive & ((state == ST_IDLE) | (state == ST_ACCUM));
  assign accept    = in_valid & in_ready;
  assign at_limit  = (count == CW'((1 << GUARD) - 1));
  assign terminal  = in_last | at_limit;
  assign out_valid = (state == ST_DONE);
  assign out_sum   = res;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      alive <= 1'b0;
      s_q   <= '0;
      c_q   <= '0;
      count <= '0;
      idx   <= '0;
      carry <= 1'b0;
      res   <= '0;
      ovf   <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            s_q   <= s_nxt;
            c_q   <= c_nxt;
            count <= count + CW'(1);
            if (terminal) begin
              state <= ST_RESOLVE;
              // Overflow only when the beat limit, not in_last, ended the frame
              ovf   <= ~in_last;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_RESOLVE: begin
          // Carry out of the top slice is dropped; it is zero within the limit
          carry <= slice[CHUNK];
          for (int i = 0; i < OW; i++) begin
            if ((i / CHUNK) == int'(idx)) res[i] <= slice[i % CHUNK];
          end
          if (idx == IW'(NR - 1)) begin
            idx   <= '0;
            state <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
            s_q   <= '0;
            c_q   <= '0;
            count <= '0;
            carry <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csa_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_accum_pipe
// Purpose  : Self-checking bench for csa_accum_pipe with default parameters
//            (WIDTH=16, GUARD=4, CHUNK=8 -> 22-bit result, 3 resolve cycles).
//            Expected sums follow CSA_SIGNED_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_accum_pipe;

  localparam int WIDTH = 16;
  localparam int GUARD = 4;
  localparam int OW    = WIDTH + 2 + GUARD;
  localparam int NR    = 3;

  logic             clk, rst_n;
  logic             in_valid, in_ready, in_last;
  logic [WIDTH-1:0] in_a, in_b, in_c;
  logic             out_valid, out_ready, out_ovf;
  logic [OW-1:0]    out_sum;

  csa_accum_pipe #(.WIDTH(WIDTH), .GUARD(GUARD), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one beat at the current negedge; it is accepted on the next posedge.
  task automatic drive_beat(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic last);
    int n = 0;
    in_a = a; in_b = b; in_c = c; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait for out_valid from the negedge following the terminal-beat accept.
  task automatic wait_result(input string name, input logic [OW-1:0] exp_sum,
                             input logic exp_ovf, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat >= 0) check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_sum"}, 32'(out_sum), 32'(exp_sum));
    check({name, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
  endtask

  // Consume the result after hold cycles of backpressure.
  task automatic consume(input string name, input int hold);
    logic [OW-1:0] s0;
    s0 = out_sum;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_sum"},   32'(out_sum),   32'(s0));
      check({name, "_hold_ready"}, 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({name, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({name, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  typedef struct {
    logic [15:0]   a, b, c;
    logic [OW-1:0] sum;
  } vec_t;

  vec_t vecs[6];

  initial begin
`ifdef CSA_SIGNED_EN
    vecs[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 22'h3FFFFD};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'h0002, 22'h000002};
    vecs[4] = '{16'h8000, 16'h8000, 16'h8000, 22'h3E8000};
`else
    vecs[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 22'h02FFFD};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'h0002, 22'h010002};
    vecs[4] = '{16'h8000, 16'h8000, 16'h8000, 22'h018000};
`endif
    vecs[1] = '{16'h0005, 16'h0006, 16'h0007, 22'h000012};
    vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 22'h000000};
    vecs[5] = '{16'h1234, 16'h4321, 16'h1111, 22'h006666};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Single-beat frames
    for (int i = 0; i < 6; i++) begin
      drive_beat(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);
      in_valid = 1'b0;
      wait_result($sformatf("vec%0d", i), vecs[i].sum, 1'b0, NR);
      consume($sformatf("vec%0d", i), (i == 0) ? 5 : 0);
    end

    // Sixteen back-to-back beats, in_last on the last one
    for (int i = 0; i < 16; i++) begin
      check("b2b_ready", 32'(in_ready), 32'd1);
      drive_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, (i == 15));
    end
    in_valid = 1'b0;
`ifdef CSA_SIGNED_EN
    wait_result("b2b16", 22'h3FFFD0, 1'b0, NR);
`else
    wait_result("b2b16", 22'h2FFFD0, 1'b0, NR);
`endif
    consume("b2b16", 0);

    // Beat limit: no in_last; a 17th beat stays pending until the next frame
    for (int i = 0; i < 16; i++) drive_beat(16'h0001, 16'h0000, 16'h0000, 1'b0);
    in_last = 1'b1;
    check("limit_ready_low", 32'(in_ready), 32'd0);
    wait_result("limit", 22'h000010, 1'b1, NR);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("limit_next_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    wait_result("beat17", 22'h000001, 1'b0, NR);
    consume("beat17", 0);

    // Reset one cycle into RESOLVE, then a clean frame
    drive_beat(16'h0009, 16'h0009, 16'h0009, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstres_valid", 32'(out_valid), 32'd0);
    check("rstres_ready", 32'(in_ready),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    drive_beat(16'h0005, 16'h0006, 16'h0007, 1'b1);
    in_valid = 1'b0;
    wait_result("after_rst", 22'h000012, 1'b0, NR);

    // Reset while DONE must drop out_valid asynchronously
    #2 rst_n = 1'b0;
    #1;
    check("rstdone_valid", 32'(out_valid), 32'd0);
    check("rstdone_sum",   32'(out_sum),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // out_ready pulse while idle has no effect
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready_valid", 32'(out_valid), 32'd0);
    drive_beat(16'h0001, 16'h0002, 16'h0003, 1'b1);
    in_valid = 1'b0;
    wait_result("idle_oready", 22'h000006, 1'b0, NR);
    consume("idle_oready", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
